alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage ALU: consumes the 4-bit ALU control code from the ALU control decoder plus two operands.
//  Logic/add/sub/slt complete in 1 cycle; multu/divu (the codes missing from the decoder) run iteratively.
//  Valid/ready on both sides so the multi-cycle path can stall the pipeline.
// PARAMETERS
//  WIDTH   32  operand/result width; mul/div iteration count = WIDTH
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      operation offered
//  in_ready    out  1      unit can accept (state IDLE)
//  alu_ctrl    in   4      0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MULTU, 1001 DIVU
//  op_a        in   WIDTH  operand A (dividend for DIVU)
//  op_b        in   WIDTH  operand B (divisor for DIVU)
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer takes result
//  result      out  WIDTH  ALU result / MULTU low word / DIVU quotient
//  result_hi   out  WIDTH  MULTU high word / DIVU remainder; 0 for 1-cycle ops
//  zero        out  1      result == 0 (branch compare)
//  ovf         out  1      signed overflow, ADD/SUB only; else 0
//  err         out  1      unsupported code (incl. DIVU when divider compiled out)
// BEHAVIOUR
//  Reset (async): state IDLE; out_valid, result, result_hi, zero, ovf, err = 0; in-flight op discarded.
//  FSM: IDLE -> DONE (1-cycle ops, err) | MUL | DIV; MUL/DIV -> DONE after WIDTH iterations;
//       DONE -> IDLE when out_ready.
//  in_ready = (state == IDLE); handshake at T when in_valid && in_ready; operands/code captured at T.
//  Latency: 1-cycle ops out_valid at T+1; MULTU/DIVU out_valid at T+WIDTH+1.
//  Backpressure: out_valid && !out_ready holds all outputs stable; no new accept until DONE exits.
//  No accept in DONE cycle (no same-cycle turnaround); next accept earliest the cycle after out_ready.
//  ADD/SUB modulo 2^WIDTH; ovf = signed overflow of the op. SLT signed compare, result 0 or 1.
//  MULTU: unsigned shift-add, one bit per cycle, 2*WIDTH product {result_hi,result}.
//  DIVU: restoring, one bit per cycle, unsigned. Divide by zero: result = all-ones, result_hi = op_a.
//  Unknown alu_ctrl: 1-cycle path, result = 0, result_hi = 0, zero = 1, err = 1.
//  zero computed on result only, all ops.
//  in_valid low or alu_ctrl changing while busy: ignored.
// CONFIGURATION
//  ALU_DIV_EN defined: divider datapath built, 1001 executes DIVU as above.
//  ALU_DIV_EN undefined: no divider logic; 1001 treated as unknown code (1-cycle, err = 1).
// STRUCTURE
//  alu_pkg: ALU control code localparams (shared with the ALU control decoder), FSM state encoding.
//  Sub-module alu_seq_muldiv: iterative shift-add multiplier + restoring divider,
//    start/busy/done, shared WIDTH-cycle counter.
//    Top holds FSM, 1-cycle datapath, output registers.
// TESTING
//  ADD 5+7 -> result 12, zero 0, ovf 0, out_valid at T+1.
//  SUB 0x7FFFFFFF - 0xFFFFFFFF -> result 0x80000000, ovf 1; SUB 5-5 -> zero 1.
//  SLT 0xFFFFFFFF vs 1 -> result 1; AND 0xF0F0 & 0x0FF0 -> 0x00F0.
//  MULTU 0xFFFFFFFF*2 -> result 0xFFFFFFFE, result_hi 1, out_valid at T+33, in_ready low T+1..T+33.
//  DIVU 100/7 -> 14 rem 2; DIVU 9/0 -> 0xFFFFFFFF rem 9; ALU_DIV_EN off -> err 1 at T+1.
//  out_ready low 5 cycles on MULTU result -> outputs stable; rst pulsed mid-MULTU -> IDLE, out_valid 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU.
//  - ALU control codes, which are also used by the ALU control decoder.
//  - Execute-unit FSM state encoding.
//  - Signed-overflow helpers for ADD/SUB.
// Optional feature macro: ALU_DIV_EN (see alu_exec_unit / alu_seq_muldiv).
// ----------------------------------------------------------------------------
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;

  // Execute-unit FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } alu_state_e;

  // Signed overflow of a + b: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  // Signed overflow of a - b: operands differ in sign, difference sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic diff_msb);
    return (a_msb != b_msb) && (diff_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ----------------------------------------------------------------------------
// alu_exec_unit_if
// Request/response bundle of the execute-stage ALU.
//  Request : in_valid, in_ready, alu_ctrl[3:0], op_a, op_b
//  Response: out_valid, out_ready, result, result_hi, zero, ovf, err
//  master  : issuing pipeline side (drives requests, consumes results)
//  slave   : the ALU execute unit
// ----------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, ovf, err
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, ovf, err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// ----------------------------------------------------------------------------
// alu_seq_muldiv
// Iterative unsigned multiplier (shift-add) and, when ALU_DIV_EN is defined,
// restoring unsigned divider. One bit per cycle, WIDTH iterations, one shared
// iteration counter.
// The first iteration is performed on the start edge directly from the
// operand inputs, so done pulses in the cycle after the WIDTH-th iteration
// and lo/hi hold the final value while done is high.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  start      begin an operation (operands sampled this cycle)
//  div_sel    1 = divide, 0 = multiply (only present with ALU_DIV_EN)
//  a, b       multiplicand/multiplier or dividend/divisor
//  done       one-cycle pulse, lo/hi valid
//  lo, hi     product {hi,lo}, or quotient (lo) and remainder (hi)
// ----------------------------------------------------------------------------
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             div_sel,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] b_r;

  logic [WIDTH-1:0] cur_lo_s;
  logic [WIDTH-1:0] cur_hi_s;
  logic [WIDTH-1:0] cur_b_s;
  logic [WIDTH-1:0] nxt_lo_s;
  logic [WIDTH-1:0] nxt_hi_s;
  logic [WIDTH:0]   mul_sum_s;

`ifdef ALU_DIV_EN
  logic             div_r;
  logic             cur_div_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
`endif

  // Iteration source: fresh operands on start, working registers otherwise
  always_comb begin
    if (start) begin
      cur_lo_s = a;
      cur_hi_s = {WIDTH{1'b0}};
      cur_b_s  = b;
    end else begin
      cur_lo_s = lo_r;
      cur_hi_s = hi_r;
      cur_b_s  = b_r;
    end
  end

  // One multiply or divide step
  always_comb begin
    // Shift-add: conditionally add multiplicand to the high half, then
    // shift {carry,hi,lo} right; lo retires multiplier bits from the bottom.
    mul_sum_s = {1'b0, cur_hi_s} + (cur_lo_s[0] ? {1'b0, cur_b_s} : {(WIDTH+1){1'b0}});
    nxt_hi_s  = mul_sum_s[WIDTH:1];
    nxt_lo_s  = {mul_sum_s[0], cur_lo_s[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    if (start) begin
      cur_div_s = div_sel;
    end else begin
      cur_div_s = div_r;
    end
    // Restoring: hi is the partial remainder, lo shifts dividend bits out of
    // the top and quotient bits in at the bottom. Bit WIDTH of the difference
    // is the borrow. With a zero divisor no step ever borrows, so the
    // quotient becomes all ones and the remainder ends up equal to the dividend.
    div_shift_s = {cur_hi_s, cur_lo_s[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, cur_b_s};
    if (cur_div_s) begin
      if (div_diff_s[WIDTH]) begin
        nxt_hi_s = div_shift_s[WIDTH-1:0];
        nxt_lo_s = {cur_lo_s[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi_s = div_diff_s[WIDTH-1:0];
        nxt_lo_s = {cur_lo_s[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_hi_s = mul_sum_s[WIDTH:1];
      nxt_lo_s = {mul_sum_s[0], cur_lo_s[WIDTH-1:1]};
    end
`endif
  end

  // Working registers, shared iteration counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      lo_r   <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
      div_r  <= 1'b0;
`endif
    end else if (start) begin
      cnt_r  <= CNT_ONE;
      busy_r <= 1'b1;
      done_r <= 1'b0;
      lo_r   <= nxt_lo_s;
      hi_r   <= nxt_hi_s;
      b_r    <= b;
`ifdef ALU_DIV_EN
      div_r  <= div_sel;
`endif
    end else if (busy_r) begin
      cnt_r <= cnt_r + CNT_ONE;
      lo_r  <= nxt_lo_s;
      hi_r  <= nxt_hi_s;
      if (cnt_r == CNT_LAST) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign lo   = lo_r;
  assign hi   = hi_r;

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with valid/ready on both sides. AND/OR/ADD/SUB/SLT and
// unknown codes complete in one cycle; MULTU (and DIVU when ALU_DIV_EN is
// defined) run for WIDTH cycles in alu_seq_muldiv. Without ALU_DIV_EN the
// DIVU code is reported as unsupported (err = 1).
// Ports:
//  clk   rising-edge clock
//  rst   asynchronous active-high reset
//  bus   alu_exec_unit_if.slave:
//        in_valid/in_ready/alu_ctrl/op_a/op_b  request, accepted only in IDLE
//        out_valid/out_ready                   response handshake
//        result, result_hi, zero, ovf, err     registered, held until taken
// ----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_unit_if.slave bus
);

  alu_state_e       state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             zero_r;
  logic             ovf_r;
  logic             err_r;

  logic             accept_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             md_start_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH-1:0] md_hi_s;

  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_ovf_s;
  logic             sc_err_s;

  assign accept_s = (state_r == ST_IDLE) && bus.in_valid;
  assign is_mul_s = (bus.alu_ctrl == ALU_MULTU);
`ifdef ALU_DIV_EN
  assign is_div_s = (bus.alu_ctrl == ALU_DIVU);
`else
  assign is_div_s = 1'b0;
`endif
  assign md_start_s = accept_s && (is_mul_s || is_div_s);

  assign add_s = bus.op_a + bus.op_b;
  assign sub_s = bus.op_a - bus.op_b;

  // Single-cycle datapath, evaluated on the accepted request
  always_comb begin
    sc_result_s = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    sc_err_s    = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: sc_result_s = bus.op_a & bus.op_b;
      ALU_OR:  sc_result_s = bus.op_a | bus.op_b;
      ALU_ADD: begin
        sc_result_s = add_s;
        sc_ovf_s    = add_ovf(bus.op_a[WIDTH-1], bus.op_b[WIDTH-1], add_s[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_result_s = sub_s;
        sc_ovf_s    = sub_ovf(bus.op_a[WIDTH-1], bus.op_b[WIDTH-1], sub_s[WIDTH-1]);
      end
      ALU_SLT: sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      default: sc_err_s = 1'b1;
    endcase
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start_s),
`ifdef ALU_DIV_EN
    .div_sel (is_div_s),
`endif
    .a       (bus.op_a),
    .b       (bus.op_b),
    .done    (md_done_s),
    .lo      (md_lo_s),
    .hi      (md_hi_s)
  );

  // Control FSM and registered response; outputs hold while DONE waits for out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (md_start_s) begin
              state_r <= is_div_s ? ST_DIV : ST_MUL;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= sc_result_s;
              result_hi_r <= {WIDTH{1'b0}};
              zero_r      <= (sc_result_s == {WIDTH{1'b0}});
              ovf_r       <= sc_ovf_s;
              err_r       <= sc_err_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= md_lo_s;
            result_hi_r <= md_hi_s;
            zero_r      <= (md_lo_s == {WIDTH{1'b0}});
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DONE: begin
          // Return to IDLE only after the result is taken; accept resumes next cycle
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed stimulus with hand-computed literals, plus a behavioural model
// (plain arithmetic) whose expected responses are queued on each accepted
// request and checked against the DUT every cycle out_valid is high.
// Honours ALU_DIV_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected response from the arithmetic definition of each code
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [63:0] p;
    e.res = 32'd0; e.hi = 32'd0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: begin
        sr = sa + sb;
        e.res = a + b;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_SUB: begin
        sr = sa - sb;
        e.res = a - b;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.hi  = p[63:32];
        e.lat = W + 1;
      end
`ifdef ALU_DIV_EN
      ALU_DIVU: begin
        if (b == 32'd0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = a;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
        e.lat = W + 1;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Compare process: every cycle a result is presented
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          check("result",    bus.result,    exp_q[0].res);
          check("result_hi", bus.result_hi, exp_q[0].hi);
          check("zero",      bus.zero,      exp_q[0].zero);
          check("ovf",       bus.ovf,       exp_q[0].ovf);
          check("err",       bus.err,       exp_q[0].err);
          if (bus.out_ready) exp_q.pop_front();
        end
      end
    end
  end

  // Issue one request, measure latency, hold backpressure, then take the result
  task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lit_res,
                        input logic [W-1:0] lit_hi, input int hold);
    exp_t e;
    int   n;
    e = model(c, a, b);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_ready_idle"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    // Busy-time input changes must be ignored
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 4'b0010;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid) check({name, "_in_ready_busy"}, bus.in_ready, 1'b0);
    end while (!bus.out_valid && n < 100);
    check({name, "_latency"},   n,             e.lat);
    check({name, "_lit_res"},   bus.result,    lit_res);
    check({name, "_lit_hi"},    bus.result_hi, lit_hi);
    check({name, "_no_accept"}, bus.in_ready,  1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, bus.out_valid, 1'b1);
      check({name, "_hold_res"},   bus.result,    lit_res);
      check({name, "_hold_hi"},    bus.result_hi, lit_hi);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_drop"}, bus.out_valid, 1'b0);
    check({name, "_ready_back"}, bus.in_ready,  1'b1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int   seen;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'b0000;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b0;

    // Model pins
    m = model(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("pin_sub_res", m.res, 32'h8000_0000);
    check("pin_sub_ovf", m.ovf, 1'b1);
    m = model(ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("pin_mul_hi",  m.hi,  32'd1);
    check("pin_mul_lat", m.lat, 33);
    m = model(4'b1111, 32'd3, 32'd4);
    check("pin_unk_err",  m.err,  1'b1);
    check("pin_unk_zero", m.zero, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_result",    bus.result,    32'd0);
    check("rst_result_hi", bus.result_hi, 32'd0);
    check("rst_zero",      bus.zero,      1'b0);
    check("rst_ovf",       bus.ovf,       1'b0);
    check("rst_err",       bus.err,       1'b0);

    run_op("add",      ALU_ADD,   32'd5,          32'd7,          32'd12,         32'd0, 0);
    run_op("sub_ovf",  ALU_SUB,   32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0, 0);
    run_op("sub_zero", ALU_SUB,   32'd5,          32'd5,          32'd0,          32'd0, 2);
    run_op("slt",      ALU_SLT,   32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0, 0);
    run_op("slt_no",   ALU_SLT,   32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0, 0);
    run_op("and",      ALU_AND,   32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  32'd0, 0);
    run_op("or",       ALU_OR,    32'h0000_F000,  32'h0000_000F,  32'h0000_F00F,  32'd0, 0);
    run_op("add_ovf",  ALU_ADD,   32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  32'd0, 0);
    run_op("mul",      ALU_MULTU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1, 5);
    run_op("mul_zero", ALU_MULTU, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd1, 0);
`ifdef ALU_DIV_EN
    run_op("div",      ALU_DIVU,  32'd100,        32'd7,          32'd14,         32'd2, 0);
    run_op("div_zero", ALU_DIVU,  32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 0);
`else
    run_op("div_off",  ALU_DIVU,  32'd100,        32'd7,          32'd0,          32'd0, 0);
`endif
    run_op("unknown",  4'b1111,   32'd3,          32'd4,          32'd0,          32'd0, 0);

    // Reset in the middle of a MULTU
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ALU_MULTU;
    bus.op_a     = 32'd6;
    bus.op_b     = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready",  bus.in_ready,  1'b1);
    check("midrst_result",    bus.result,    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);
    run_op("post_rst", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
